// File: rtl/seg_scan_scheduler_pkg.sv
// Shared types and constants for the seven-segment scan scheduler.
// Source encoding, slot FSM states, segment patterns and nibble/enable helpers.
package seg_scan_scheduler_pkg;

    typedef enum logic {
        SRC_TIMER = 1'b0,
        SRC_MSG   = 1'b1
    } src_e;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } slot_st_e;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Digit index 0 is the min digit, held in the top nibble
    function automatic logic [3:0] digit_nibble(input logic [15:0] word, input logic [1:0] idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = word[15:12];
            2'd1:    nib = word[11:8];
            2'd2:    nib = word[7:4];
            default: nib = word[3:0];
        endcase
        return nib;
    endfunction

    function automatic logic [3:0] digit_enable_n(input logic [1:0] idx);
        return ~(4'b1000 >> idx);
    endfunction

endpackage

// File: rtl/seg_scan_scheduler_seg7_decode.sv
// Combinational code to active-low segment decoder shared by timer and message sources.
// Timer codes 10-15 blank; message code A is a dash; suppress blanks a zero.
module seg7_decode
    import seg_scan_scheduler_pkg::*;
(
    input  logic [3:0] code,
    input  logic       is_msg,
    input  logic       suppress,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (code)
            4'd0:    seg_n = 7'h40;
            4'd1:    seg_n = 7'h79;
            4'd2:    seg_n = 7'h24;
            4'd3:    seg_n = 7'h30;
            4'd4:    seg_n = 7'h19;
            4'd5:    seg_n = 7'h12;
            4'd6:    seg_n = 7'h02;
            4'd7:    seg_n = 7'h78;
            4'd8:    seg_n = 7'h00;
            4'd9:    seg_n = 7'h10;
            4'hA:    seg_n = is_msg ? SEG_DASH : SEG_BLANK;
            default: seg_n = SEG_BLANK;
        endcase
        if (suppress && (code == 4'd0)) begin
            seg_n = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Scan controller for the shared 4-digit display: per-frame timer/message arbitration,
// blanked digit slots and registered pin outputs. Timer blink built in with SEG_SCAN_BLINK_EN.
module seg_scan_scheduler
    import seg_scan_scheduler_pkg::*;
#(
    parameter int unsigned DIGIT_TICKS       = 24000,
    parameter int unsigned BLANK_TICKS       = 240,
    parameter int unsigned MSG_HOLD_FRAMES   = 500,
    parameter int unsigned BLINK_HALF_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] timer_digits,
    input  logic        msg_req,
    input  logic [15:0] msg_digits,
    output logic        msg_ack,
    input  logic        blink_en,
    output logic [3:0]  dig_n,
    output logic [6:0]  seg_n,
    output logic        dp_n
);

    // state    | meaning
    // ST_BLANK | leading cycles of a slot, all digits off, segments reloaded
    // ST_ON    | selected digit enabled for the remainder of the slot

    localparam int unsigned SLOT_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int unsigned HOLD_W = $clog2(MSG_HOLD_FRAMES + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGIT_TICKS - 1);
    localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MSG_HOLD_FRAMES);

    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]        dig_idx_q, dig_idx_d;
    slot_st_e          state_q, state_d;
    src_e              src_q, src_d;
    logic [15:0]       snap_q, snap_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              msg_ack_q, msg_ack_d;
    logic [3:0]        dig_n_q, dig_n_d;
    logic [6:0]        seg_n_q, seg_n_d;
    logic              dp_n_q, dp_n_d;

    logic              frame_start;
    logic              frame_dark;
    logic [3:0]        dec_code;
    logic              dec_is_msg;
    logic              dec_suppress;
    logic [6:0]        dec_seg_n;

    assign frame_start = (slot_cnt_q == '0) && (dig_idx_q == 2'd0);

`ifdef SEG_SCAN_BLINK_EN
    localparam int unsigned BLINK_W = $clog2(BLINK_HALF_FRAMES + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_FRAMES);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_off_q, blink_off_d;

    // Count restarts at 1 on each toggle, so a fresh enable gives a full on-phase first
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (frame_start) begin
            if (!blink_en) begin
                blink_cnt_d = '0;
                blink_off_d = 1'b0;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = BLINK_W'(1);
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end

    assign frame_dark = blink_off_q && (src_q == SRC_TIMER);
`else
    localparam int unsigned unused_blink_half = BLINK_HALF_FRAMES;
    logic unused_blink_en;
    assign unused_blink_en = blink_en;
    assign frame_dark      = 1'b0;
`endif

    seg7_decode u_decode (
        .code     (dec_code),
        .is_msg   (dec_is_msg),
        .suppress (dec_suppress),
        .seg_n    (dec_seg_n)
    );

    always_comb begin
        slot_cnt_d = (slot_cnt_q == SLOT_LAST) ? '0 : slot_cnt_q + 1'b1;
        dig_idx_d  = (slot_cnt_q == SLOT_LAST) ? dig_idx_q + 2'd1 : dig_idx_q;
        state_d    = (slot_cnt_d < BLANK_END) ? ST_BLANK : ST_ON;

        src_d     = src_q;
        hold_d    = hold_q;
        snap_d    = snap_q;
        msg_ack_d = 1'b0;
        if (frame_start) begin
            if (src_q == SRC_MSG) begin
                hold_d = hold_q - 1'b1;
                if (hold_d == '0) begin
                    src_d = SRC_TIMER;
                end
            end
            // Evaluated after hold expiry so a held request is re-granted back-to-back
            if ((src_d == SRC_TIMER) && msg_req) begin
                src_d     = SRC_MSG;
                hold_d    = HOLD_LOAD;
                msg_ack_d = 1'b1;
            end
            snap_d = (src_d == SRC_MSG) ? msg_digits : timer_digits;
        end

        // Uses the _d view so digit 0 decodes the snapshot being taken this cycle
        dec_code     = digit_nibble(snap_d, dig_idx_q);
        dec_is_msg   = (src_d == SRC_MSG);
        dec_suppress = (src_d == SRC_TIMER) && (dig_idx_q == 2'd0);

        seg_n_d = seg_n_q;
        dp_n_d  = dp_n_q;
        if (slot_cnt_q == '0) begin
            seg_n_d = dec_seg_n;
            dp_n_d  = !((src_d == SRC_TIMER) && (dig_idx_q == 2'd2));
        end

        dig_n_d = 4'b1111;
        if ((state_q == ST_ON) && !frame_dark) begin
            dig_n_d = digit_enable_n(dig_idx_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt_q <= '0;
            dig_idx_q  <= 2'd0;
            state_q    <= ST_BLANK;
            src_q      <= SRC_TIMER;
            snap_q     <= '0;
            hold_q     <= '0;
            msg_ack_q  <= 1'b0;
            dig_n_q    <= 4'b1111;
            seg_n_q    <= SEG_BLANK;
            dp_n_q     <= 1'b1;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            dig_idx_q  <= dig_idx_d;
            state_q    <= state_d;
            src_q      <= src_d;
            snap_q     <= snap_d;
            hold_q     <= hold_d;
            msg_ack_q  <= msg_ack_d;
            dig_n_q    <= dig_n_d;
            seg_n_q    <= seg_n_d;
            dp_n_q     <= dp_n_d;
        end
    end

    assign msg_ack = msg_ack_q;
    assign dig_n   = dig_n_q;
    assign seg_n   = seg_n_q;
    assign dp_n    = dp_n_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler: a frame-level model pushes expected digit slots,
// a pin monitor pops and compares them as each slot completes on the display outputs.
module tb_seg_scan_scheduler;

    localparam int DT    = 10;
    localparam int BT    = 2;
    localparam int HOLD  = 3;
    localparam int HALF  = 2;
    localparam int FRAME = 4 * DT;

    logic        clk;
    logic        rst;
    logic [15:0] timer_digits;
    logic        msg_req;
    logic [15:0] msg_digits;
    logic        msg_ack;
    logic        blink_en;
    logic [3:0]  dig_n;
    logic [6:0]  seg_n;
    logic        dp_n;

    seg_scan_scheduler #(
        .DIGIT_TICKS       (DT),
        .BLANK_TICKS       (BT),
        .MSG_HOLD_FRAMES   (HOLD),
        .BLINK_HALF_FRAMES (HALF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .timer_digits (timer_digits),
        .msg_req      (msg_req),
        .msg_digits   (msg_digits),
        .msg_ack      (msg_ack),
        .blink_en     (blink_en),
        .dig_n        (dig_n),
        .seg_n        (seg_n),
        .dp_n         (dp_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dig;
        logic [6:0] seg;
        logic       dp;
        int         blank;
    } slot_t;

    slot_t exp_q[$];

    int   n_total    = 0;
    int   n_pass     = 0;
    int   msg_left   = 0;
    int   blink_k    = 0;
    int   pend_blank = BT;
    int   acks_exp   = 0;
    int   acks_seen  = 0;
    logic exp_ack;

    // Active-high {g,f,e,d,c,b,a} for 0..9
    logic [6:0] seg_hi [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [6:0] exp_seg(input logic [3:0] nib, input logic msg, input logic sup);
        if (nib <= 4'd9) return (sup && nib == 4'd0) ? 7'h7F : ~seg_hi[nib];
        if (msg && nib == 4'hA) return ~7'h40;
        return 7'h7F;
    endfunction

    // Frame-start model: arbitration, snapshot and blink phase; pushes the frame's slots
    task automatic frame_model(input logic [15:0] td, input logic req);
        logic        is_msg;
        logic        dark;
        logic [15:0] w;
        logic [3:0]  nib;
        slot_t       s;
        if (msg_left > 0) msg_left--;
        exp_ack = 1'b0;
        if (msg_left == 0 && req) begin
            msg_left = HOLD;
            exp_ack  = 1'b1;
            acks_exp++;
        end
        is_msg = (msg_left > 0);
        w      = is_msg ? msg_digits : td;
        dark   = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
        if (!blink_en) blink_k = 0;
        else begin
            dark = !is_msg && (((blink_k / HALF) % 2) == 1);
            blink_k++;
        end
`endif
        if (dark) pend_blank += FRAME;
        else begin
            for (int i = 0; i < 4; i++) begin
                nib     = w[15 - 4*i -: 4];
                s.dig   = ~(4'b1000 >> i);
                s.seg   = exp_seg(nib, is_msg, !is_msg && i == 0);
                s.dp    = !(!is_msg && i == 2);
                s.blank = (i == 0) ? pend_blank : BT;
                exp_q.push_back(s);
            end
            pend_blank = BT;
        end
    endtask

    // Called just before a frame-start edge; returns just before the next one
    task automatic run_frame(input logic [15:0] td0, input logic req0,
                             input logic [15:0] td1, input logic req1);
        timer_digits = td0;
        msg_req      = req0;
        frame_model(td0, req0);
        @(negedge clk);
        chk("ack_pulse", msg_ack, exp_ack);
        @(negedge clk);
        chk("ack_width", msg_ack, 1'b0);
        repeat (23) @(negedge clk);
        timer_digits = td1;
        msg_req      = req1;
        repeat (15) @(negedge clk);
    endtask

    // Pin monitor: groups each enabled-digit run into a slot and checks it on completion
    initial begin : monitor
        logic       in_run;
        logic       run_ok;
        logic [3:0] run_dig;
        logic [6:0] run_seg;
        logic       run_dp;
        int         run_len;
        int         run_blank;
        int         blank_run;
        slot_t      e;
        in_run    = 1'b0;
        blank_run = 0;
        run_ok    = 1'b1;
        run_dig   = 4'hF;
        run_seg   = 7'h7F;
        run_dp    = 1'b1;
        run_len   = 0;
        run_blank = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_run    = 1'b0;
                blank_run = 0;
            end else begin
                if (msg_ack === 1'b1) acks_seen++;
                if (dig_n !== 4'hF) begin
                    if (!in_run) begin
                        in_run    = 1'b1;
                        run_dig   = dig_n;
                        run_seg   = seg_n;
                        run_dp    = dp_n;
                        run_len   = 0;
                        run_ok    = 1'b1;
                        run_blank = blank_run;
                    end else if (dig_n !== run_dig || seg_n !== run_seg || dp_n !== run_dp) begin
                        run_ok = 1'b0;
                    end
                    run_len++;
                    blank_run = 0;
                end else begin
                    if (in_run) begin
                        in_run = 1'b0;
                        if (exp_q.size() == 0) chk("slot_unexpected", run_dig, 4'hF);
                        else begin
                            e = exp_q.pop_front();
                            chk("slot_dig", run_dig, e.dig);
                            chk("slot_seg", run_seg, e.seg);
                            chk("slot_dp", run_dp, e.dp);
                            chk("slot_on_len", run_len, DT - BT);
                            chk("slot_blank_len", run_blank, e.blank);
                            chk("slot_stable", run_ok, 1'b1);
                        end
                    end
                    blank_run++;
                end
            end
        end
    end

    initial begin : stimulus
        rst          = 1'b0;
        timer_digits = 16'h1234;
        msg_req      = 1'b0;
        msg_digits   = 16'hAAAA;
        blink_en     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dig_n", dig_n, 4'hF);
        chk("rst_seg_n", seg_n, 7'h7F);
        chk("rst_dp_n", dp_n, 1'b1);
        chk("rst_msg_ack", msg_ack, 1'b0);
        #1 rst = 1'b1;

        // Basic scan, then leading-zero suppression
        run_frame(16'h1234, 1'b0, 16'h1234, 1'b0);
        run_frame(16'h0507, 1'b0, 16'h0507, 1'b0);

        // Mid-frame request, 3-frame message, timer returns
        run_frame(16'h1234, 1'b0, 16'h1234, 1'b1);
        run_frame(16'h1234, 1'b1, 16'h1234, 1'b0);
        run_frame(16'h1234, 1'b0, 16'h1234, 1'b0);
        run_frame(16'h1234, 1'b0, 16'h1234, 1'b0);
        run_frame(16'h1234, 1'b0, 16'h1234, 1'b0);

        // Held request: back-to-back grants, timer never shown
        msg_digits = 16'h0A9B;
        for (int f = 0; f < 7; f++) run_frame(16'h9876, 1'b1, 16'h9876, f < 6);
        run_frame(16'h9876, 1'b0, 16'h9876, 1'b0);
        run_frame(16'h9876, 1'b0, 16'h9876, 1'b0);
        run_frame(16'h9876, 1'b0, 16'h9876, 1'b0);

        // Input change in slot 2 lands on the next frame
        run_frame(16'h1234, 1'b0, 16'h5678, 1'b0);
        run_frame(16'h5678, 1'b0, 16'h5678, 1'b0);

        // Blink (no effect when the feature is not built), message during off phase
        msg_digits = 16'hAAAA;
        blink_en   = 1'b1;
        run_frame(16'h1234, 1'b0, 16'h1234, 1'b0);
        run_frame(16'h1234, 1'b0, 16'h1234, 1'b0);
        run_frame(16'h1234, 1'b0, 16'h1234, 1'b1);
        run_frame(16'h1234, 1'b1, 16'h1234, 1'b0);
        for (int f = 0; f < 5; f++) run_frame(16'h2468, 1'b0, 16'h2468, 1'b0);
        blink_en = 1'b0;
        run_frame(16'h1357, 1'b0, 16'h1357, 1'b0);

        // Reset in the middle of a granted message
        msg_digits   = 16'hA0A0;
        timer_digits = 16'h1234;
        msg_req      = 1'b1;
        frame_model(16'h1234, 1'b1);
        @(negedge clk);
        chk("mid_ack", msg_ack, exp_ack);
        repeat (14) @(negedge clk);
        #2 rst = 1'b0;
        msg_req = 1'b0;
        #1;
        chk("mid_rst_dig_n", dig_n, 4'hF);
        chk("mid_rst_seg_n", seg_n, 7'h7F);
        chk("mid_rst_dp_n", dp_n, 1'b1);
        chk("mid_rst_ack", msg_ack, 1'b0);
        exp_q.delete();
        msg_left   = 0;
        blink_k    = 0;
        pend_blank = BT;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        run_frame(16'h4321, 1'b0, 16'h4321, 1'b0);
        run_frame(16'h4321, 1'b0, 16'h4321, 1'b0);

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("ack_total", acks_seen, acks_exp);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg_scan_scheduler.md
# seg_scan_scheduler

Time-multiplexed scan controller for the washing-machine timer's shared 4-digit seven-segment display (min, ten_sec, sec, one_tenth_sec). It owns the common segment bus and the four active-low digit enables. Each frame it grants the display to one of two requesters, the countdown timer or a transient status message, and drives digits with anti-ghosting blanking between slots. It sits between the timer/FSM logic and the board's display pins.

## Interface
- DIGIT_TICKS, 24000: clk cycles per digit slot (1 ms at 24 MHz).
- BLANK_TICKS, 240: leading cycles of each slot with all digits off; must be < DIGIT_TICKS.
- MSG_HOLD_FRAMES, 500: frames a granted message stays displayed.
- BLINK_HALF_FRAMES, 125: frames per blink half-period.
- clk in 1: system clock.
- rst in 1: reset, asynchronous, active-low.
- timer_digits in 16: 4 BCD nibbles {min, ten_sec, sec, tenth}; [15:12] = min.
- msg_req in 1: level request to show msg_digits.
- msg_digits in 16: 4 display codes, same nibble order.
- msg_ack out 1: one-cycle pulse when the message is granted.
- blink_en in 1: blink the timer display.
- dig_n out 4: active-low digit enables; [3]=min, [2]=ten_sec, [1]=sec, [0]=tenth.
- seg_n out 7: active-low segments {g,f,e,d,c,b,a}.
- dp_n out 1: active-low decimal point.

## Operation
- A slot counter runs 0..DIGIT_TICKS-1. The digit index runs 0..3 (min first) and wraps. One frame is 4 slots.
- Per-slot FSM:
  - BLANK (slot count < BLANK_TICKS): dig_n=4'b1111. seg_n/dp_n are loaded on the first BLANK cycle.
  - ON: the selected dig_n bit is low for the rest of the slot.
- Frame start is the first cycle of slot 0. At frame start:
  - Source arbitration runs.
  - The chosen 16-bit source is snapshotted, so the frame is coherent even if inputs change mid-frame.
- Arbitration:
  - src=TIMER by default.
  - If src=TIMER and msg_req=1 at frame start, then src=MSG, msg_ack pulses in that cycle, and the hold counter loads MSG_HOLD_FRAMES.
  - The hold counter decrements at each frame start. When it reaches 0, src returns to TIMER at that frame start.
  - msg_req is ignored while src=MSG.
  - A request still high when hold ends is re-granted at that same frame start, giving back-to-back messages with a fresh ack.
- Decode, 0-9 standard:
  - TIMER source: codes 10-15 blank.
  - MSG source: 4'hA = dash (g only), 4'hB-F blank.
  - Leading-zero suppression applies to the timer source only: min digit = 0 is blanked.
- dp_n is low only for the sec digit with TIMER source; otherwise high.

## Timing
- Reset values: dig_n=4'b1111, seg_n=7'h7F, dp_n=1, msg_ack=0, src=TIMER, digit index=0, slot counter=0, FSM=BLANK, hold and blink counters=0.
- The first cycle after reset release is a frame start.
- All outputs are registered. seg_n changes only while dig_n=4'b1111.
- Input-to-display latency is at most 1 frame + BLANK_TICKS + 1 cycles.
- Reset asserted mid-slot or mid-message forces all outputs to reset values immediately. An in-progress message is dropped without a further ack.

## Configuration
- SEG_SCAN_BLINK_EN defined:
  - A frame counter toggles the blink phase every BLINK_HALF_FRAMES frames.
  - When blink_en=1, src=TIMER and the phase is off, dig_n stays 4'b1111 for whole frames.
  - Messages never blink. The phase counter resets when blink_en=0, so blinking starts with the on phase.
- Undefined: blink_en is ignored and the blink logic is absent.

## Structure
- A shared package holds:
  - the source encoding (SRC_TIMER, SRC_MSG);
  - the slot FSM states (ST_BLANK, ST_ON);
  - the segment constants SEG_BLANK=7'h7F and SEG_DASH.
- One sub-module, seg7_decode: combinational code-to-seg_n decoder with inputs code[3:0], is_msg, suppress. It is shared by both sources.

## Test plan
Use DIGIT_TICKS=10, BLANK_TICKS=2, MSG_HOLD_FRAMES=3, BLINK_HALF_FRAMES=2.
1. Reset release with timer_digits=16'h1234 produces each of the following:
   - The dig_n sequence is 0111, 1011, 1101, 1110, each low for 8 cycles after 2 all-high cycles.
   - seg_n shows 1, 2, 3, 4.
   - dp_n is low only during the sec slot.
2. timer_digits=16'h0507 shows the min digit blank with dig_n[3] still low. Digits 5, 0, 7 show normally.
3. msg_req=1 mid-frame produces all of the following:
   - msg_ack pulses at the next frame start.
   - 3 frames show msg_digits=16'hAAAA (dashes, dp_n high).
   - The timer returns at the following frame start.
4. msg_req held high continuously re-acks every 3 frames. Timer digits are never shown.
5. timer_digits changes from 16'h1234 to 16'h5678 in slot 2. The current frame still shows 1,2,3,4 and the next frame shows 5,6,7,8.
6. With SEG_SCAN_BLINK_EN defined and blink_en=1, 2 frames scan and 2 frames keep dig_n=1111, repeating. A msg_req during the off phase shows the message unblinked.
